// File: rtl/axi_ic_pkg.sv
// Shared interconnect definitions: packet-lock state, datapath mode codes and a
// modulo-increment helper used by the round-robin pointer logic.
package axi_ic_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Register-slice modes, kept in step with axi_skidbuffer
  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_FWD    = 2'd1;
  localparam logic [1:0] MODE_BWD    = 2'd2;
  localparam logic [1:0] MODE_FULL   = 2'd3;

  function automatic int unsigned wrap_inc(input int unsigned g, input int unsigned n);
    if ((g + 32'd1) >= n) begin
      return 32'd0;
    end else begin
      return g + 32'd1;
    end
  endfunction

endpackage

// File: rtl/axi_rr_pick.sv
// Rotating-priority picker: first asserted request at or above ptr, wrapping
// modulo NUM, returned both as a one-hot grant and as a binary index.
module axi_rr_pick
  import axi_ic_pkg::*;
#(
  parameter int NUM = 4,
  parameter int IW  = $clog2(NUM)
) (
  input  logic [NUM-1:0] valid,
  input  logic [IW-1:0]  ptr,
  output logic [NUM-1:0] grant,
  output logic [IW-1:0]  idx,
  output logic           any
);

  // Walk the channels starting at ptr; the first hit wins and masks the rest.
  always_comb begin
    int unsigned c;
    logic        hit;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    hit   = 1'b0;
    c     = 32'(ptr);
    for (int i = 0; i < NUM; i++) begin
      hit            = ~any & valid[IW'(c)];
      grant[IW'(c)]  = grant[IW'(c)] | hit;
      idx            = hit ? IW'(c) : idx;
      any            = any | hit;
      c              = wrap_inc(c, 32'(NUM));
    end
  end

endmodule

// File: rtl/axi_rr_arbiter.sv
// Round-robin N:1 stream arbiter with a forward-registered output stage.
// Define AXI_ARB_LAST_EN to add the s_last port and whole-packet locking.
module axi_rr_arbiter
  import axi_ic_pkg::*;
#(
  parameter int NUM = 4,
  parameter int DW  = 8,
  parameter int IW  = $clog2(NUM)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NUM*DW-1:0] s_data,
  input  logic [NUM-1:0]    s_valid,
  output logic [NUM-1:0]    s_ready,
`ifdef AXI_ARB_LAST_EN
  input  logic [NUM-1:0]    s_last,
`endif
  output logic [DW-1:0]     m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [IW-1:0]     m_id,
  output logic              m_last
);

  logic [NUM-1:0] req_s;
  logic [NUM-1:0] grant_s;
  logic [IW-1:0]  pick_idx_s;
  logic           any_s;
  logic           ld_s;
  logic           xfer_s;
  logic [DW-1:0]  sel_data_s;
  logic           sel_last_s;

  logic [IW-1:0]  ptr_q,     ptr_d;
  logic [DW-1:0]  m_data_q,  m_data_d;
  logic           m_valid_q, m_valid_d;
  logic [IW-1:0]  m_id_q,    m_id_d;
  logic           m_last_q,  m_last_d;

  axi_rr_pick #(
    .NUM (NUM),
    .IW  (IW)
  ) u_pick (
    .valid (req_s),
    .ptr   (ptr_q),
    .grant (grant_s),
    .idx   (pick_idx_s),
    .any   (any_s)
  );

  assign ld_s    = ~m_valid_q | m_ready;
  assign xfer_s  = any_s & ld_s & ~i_reset;
  assign s_ready = grant_s & {NUM{ld_s & ~i_reset}};

`ifdef AXI_ARB_LAST_EN
  lock_state_e    lock_q,  lock_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [NUM-1:0] owner_mask_s;

  assign owner_mask_s = {{(NUM-1){1'b0}}, 1'b1} << owner_q;

  // While a packet is open only its owner may compete.
  always_comb begin
    if (lock_q == LOCKED) begin
      req_s = s_valid & owner_mask_s;
    end else begin
      req_s = s_valid;
    end
  end

  // Granted-channel payload and end-of-packet flag (one-hot AND-OR mux).
  always_comb begin
    sel_data_s = '0;
    sel_last_s = 1'b0;
    for (int k = 0; k < NUM; k++) begin
      sel_data_s = sel_data_s | (s_data[k*DW +: DW] & {DW{grant_s[k]}});
      sel_last_s = sel_last_s | (s_last[k] & grant_s[k]);
    end
  end

  // Packet-lock next state: open on a non-final beat, close on the owner's final beat.
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    case (lock_q)
      IDLE: begin
        if (xfer_s && !sel_last_s) begin
          lock_d  = LOCKED;
          owner_d = pick_idx_s;
        end else begin
          lock_d  = IDLE;
        end
      end
      LOCKED: begin
        if (xfer_s && sel_last_s) begin
          lock_d = IDLE;
        end else begin
          lock_d = LOCKED;
        end
      end
      default: begin
        lock_d  = IDLE;
        owner_d = '0;
      end
    endcase
  end

  // Lock state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      lock_q  <= IDLE;
      owner_q <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end
`else
  assign req_s      = s_valid;
  assign sel_last_s = 1'b1;

  // Granted-channel payload (one-hot AND-OR mux).
  always_comb begin
    sel_data_s = '0;
    for (int k = 0; k < NUM; k++) begin
      sel_data_s = sel_data_s | (s_data[k*DW +: DW] & {DW{grant_s[k]}});
    end
  end
`endif

  // Pointer moves past the winner only when a packet (or single beat) completes.
  always_comb begin
    if (xfer_s && sel_last_s) begin
      ptr_d = IW'(wrap_inc(32'(pick_idx_s), 32'(NUM)));
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Output stage next state: load on transfer, drain when empty-able, else hold.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_id_d    = m_id_q;
    m_last_d  = m_last_q;
    if (ld_s) begin
      m_valid_d = xfer_s;
      if (xfer_s) begin
        m_data_d = sel_data_s;
        m_id_d   = pick_idx_s;
        m_last_d = sel_last_s;
      end else begin
        m_data_d = m_data_q;
      end
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // Output and pointer registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_id_q    <= '0;
      m_last_q  <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_id_q    <= m_id_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_id    = m_id_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed self-checking bench for axi_rr_arbiter (NUM=4, DW=8); the packet
// lock section is compiled only when AXI_ARB_LAST_EN is defined.
module tb_axi_rr_arbiter;

  localparam int NUM = 4;
  localparam int DW  = 8;
  localparam int IW  = 2;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic [NUM*DW-1:0] s_data;
  logic [NUM-1:0]    s_valid;
  logic [NUM-1:0]    s_ready;
  logic [DW-1:0]     m_data;
  logic              m_valid;
  logic              m_ready;
  logic [IW-1:0]     m_id;
  logic              m_last;
`ifdef AXI_ARB_LAST_EN
  logic [NUM-1:0]    s_last;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  axi_rr_arbiter #(
    .NUM (NUM),
    .DW  (DW),
    .IW  (IW)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
`ifdef AXI_ARB_LAST_EN
    .s_last  (s_last),
`endif
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_id    (m_id),
    .m_last  (m_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [DW-1:0] v);
    s_data[k*DW +: DW] = v;
  endtask

  initial begin
    i_reset = 1'b1;
    m_ready = 1'b1;
    s_valid = 4'hF;
    s_data  = '0;
    for (int k = 0; k < NUM; k++) set_data(k, 8'hA0 + 8'(k));
`ifdef AXI_ARB_LAST_EN
    s_last = 4'hF;
`endif

    // Reset: all outputs cleared, no ready even with every channel requesting
    tick();
    tick();
    chk("rst_s_ready", 32'(s_ready), 32'h0);
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_m_data",  32'(m_data),  32'h0);
    chk("rst_m_id",    32'(m_id),    32'h0);
    chk("rst_m_last",  32'(m_last),  32'h0);

    // All four valid, m_ready=1: ids 0,1,2,3,0 back to back
    i_reset = 1'b0;
    #1;
    chk("rr_first_ready", 32'(s_ready), 32'h1);
    chk("rr_no_early_valid", 32'(m_valid), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_m_valid", 32'(m_valid), 32'h1);
      chk("rr_m_id",    32'(m_id),    32'(i % 4));
      chk("rr_m_data",  32'(m_data),  32'h0A0 + 32'(i % 4));
      chk("rr_m_last",  32'(m_last),  32'h1);
    end
    s_valid = 4'b0000;
    #1;
    chk("idle_s_ready", 32'(s_ready), 32'h0);
    tick();
    chk("idle_m_valid", 32'(m_valid), 32'h0);

    // Channel 2 alone under back-pressure (ptr=1 here)
    m_ready = 1'b0;
    s_valid = 4'b0100;
    set_data(2, 8'h5C);
    #1;
    chk("stall_ready_empty", 32'(s_ready), 32'h4);
    tick();
    chk("stall_m_valid", 32'(m_valid), 32'h1);
    chk("stall_m_id",    32'(m_id),    32'h2);
    set_data(2, 8'h77);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_s_ready", 32'(s_ready), 32'h0);
      chk("stall_m_data",  32'(m_data),  32'h5C);
      chk("stall_hold_v",  32'(m_valid), 32'h1);
      tick();
    end
    m_ready = 1'b1;
    s_valid = 4'b0000;
    #1;
    chk("stall_release_data", 32'(m_data), 32'h5C);
    tick();
    chk("stall_drained", 32'(m_valid), 32'h0);

    // ptr=3 with channels 0 and 3: 3 first, then wrap to 0
    s_valid = 4'b1001;
    set_data(0, 8'hC0);
    set_data(3, 8'hC3);
    #1;
    chk("wrap_ready3", 32'(s_ready), 32'h8);
    tick();
    chk("wrap_id3",    32'(m_id),    32'h3);
    chk("wrap_data3",  32'(m_data),  32'hC3);
    chk("wrap_ready0", 32'(s_ready), 32'h1);
    tick();
    chk("wrap_id0",    32'(m_id),    32'h0);
    chk("wrap_data0",  32'(m_data),  32'hC0);
    s_valid = 4'b0000;
    tick();
    chk("wrap_drained", 32'(m_valid), 32'h0);

`ifdef AXI_ARB_LAST_EN
    // Channel 1 three-beat packet with channel 0 competing, gap mid-packet (ptr=1)
    s_last  = 4'b0000;
    s_valid = 4'b0010;
    set_data(1, 8'h11);
    #1;
    chk("lk_ready_b1", 32'(s_ready), 32'h2);
    tick();
    chk("lk_id_b1",   32'(m_id),   32'h1);
    chk("lk_data_b1", 32'(m_data), 32'h11);
    chk("lk_last_b1", 32'(m_last), 32'h0);
    s_valid = 4'b0011;
    set_data(1, 8'h12);
    #1;
    chk("lk_ready_b2", 32'(s_ready), 32'h2);
    tick();
    chk("lk_id_b2",   32'(m_id),   32'h1);
    chk("lk_data_b2", 32'(m_data), 32'h12);
    s_valid = 4'b0001;
    #1;
    chk("lk_gap_ready", 32'(s_ready), 32'h0);
    tick();
    chk("lk_gap_valid", 32'(m_valid), 32'h0);
    s_valid = 4'b0011;
    s_last  = 4'b0010;
    set_data(1, 8'h13);
    #1;
    chk("lk_ready_b3", 32'(s_ready), 32'h2);
    tick();
    chk("lk_id_b3",   32'(m_id),   32'h1);
    chk("lk_data_b3", 32'(m_data), 32'h13);
    chk("lk_last_b3", 32'(m_last), 32'h1);
    s_last = 4'b0011;
    #1;
    chk("lk_unlock_ready", 32'(s_ready), 32'h1);
    tick();
    chk("lk_ch0_id",   32'(m_id),   32'h0);
    chk("lk_ch0_last", 32'(m_last), 32'h1);
    s_last = 4'b0000;
    #1;
    chk("lk_ch1_ready", 32'(s_ready), 32'h2);
    tick();
    chk("lk_ch1_open_id",   32'(m_id),   32'h1);
    chk("lk_ch1_open_last", 32'(m_last), 32'h0);

    // Reset while a beat is held and channel 1 owns the lock
    i_reset = 1'b1;
    #1;
    chk("lk_rst_ready", 32'(s_ready), 32'h0);
    tick();
    chk("lk_rst_valid", 32'(m_valid), 32'h0);
    chk("lk_rst_id",    32'(m_id),    32'h0);
    chk("lk_rst_data",  32'(m_data),  32'h0);
    chk("lk_rst_last",  32'(m_last),  32'h0);
    i_reset = 1'b0;
    s_last  = 4'b0011;
    #1;
    chk("lk_post_rst_ready", 32'(s_ready), 32'h1);
    tick();
    chk("lk_post_rst_id", 32'(m_id), 32'h0);
    s_valid = 4'b0000;
    s_last  = 4'hF;
    tick();
    chk("lk_drained", 32'(m_valid), 32'h0);
`endif

    // Reset mid-stream: pointer returns to 0 (ptr=1 here)
    s_valid = 4'b0110;
    set_data(1, 8'h21);
    set_data(2, 8'h22);
    #1;
    chk("mr_ready1", 32'(s_ready), 32'h2);
    tick();
    chk("mr_id1",   32'(m_id),   32'h1);
    chk("mr_data1", 32'(m_data), 32'h21);
    i_reset = 1'b1;
    s_valid = 4'b0111;
    #1;
    chk("mr_rst_ready", 32'(s_ready), 32'h0);
    tick();
    chk("mr_rst_valid", 32'(m_valid), 32'h0);
    chk("mr_rst_id",    32'(m_id),    32'h0);
    chk("mr_rst_data",  32'(m_data),  32'h0);
    i_reset = 1'b0;
    #1;
    chk("mr_post_ready", 32'(s_ready), 32'h1);
    tick();
    chk("mr_post_valid", 32'(m_valid), 32'h1);
    chk("mr_post_id",    32'(m_id),    32'h0);
    chk("mr_post_data",  32'(m_data),  32'hC0);
    s_valid = 4'b0000;
    tick();
    chk("mr_drained", 32'(m_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_rr_arbiter.md
AXI_RR_ARBITER -- requirements
Module: axi_rr_arbiter

Interface
REQ-001 Parameter NUM, 4, number of upstream request channels (2..16).
REQ-002 Parameter DW, 8, payload width in bits.
REQ-003 Parameter IW, $clog2(NUM), width of grant index.
REQ-004 Single clock; reset is synchronous and active-high.
REQ-005 i_clk  input  1  clock; all state updates on rising edge.
REQ-006 i_reset  input  1  synchronous active-high reset.
REQ-007 s_data  input  NUM*DW  per-channel payloads; channel k occupies bits [k*DW +: DW].
REQ-008 s_valid  input  NUM  per-channel valid.
REQ-009 s_ready  output  NUM  per-channel ready; at most one bit high.
REQ-010 s_last  input  NUM  per-channel end-of-packet; present only with AXI_ARB_LAST_EN.
REQ-011 m_data  output  DW  registered payload toward downstream skid buffer.
REQ-012 m_valid  output  1  registered valid.
REQ-013 m_ready  input  1  downstream ready.
REQ-014 m_id  output  IW  index of the channel that supplied m_data.
REQ-015 m_last  output  1  registered copy of s_last of the winning beat; tied 1 without AXI_ARB_LAST_EN.

Function
REQ-016 Output stage is a forward register: load enable ld = ~m_valid | m_ready.
REQ-017 s_ready[k] = ld & grant[k]; a beat transfers on s_valid[k] & s_ready[k].
REQ-018 On transfer, m_data/m_id/m_last load the winner next cycle and m_valid=1; latency s_valid to m_valid exactly 1 cycle.
REQ-019 If ld=1 and no transfer, m_valid clears next cycle; if ld=0, output registers hold.
REQ-020 Sustained throughput 1 beat/cycle while m_ready=1 and any s_valid=1.
REQ-021 Grant (unlocked) = first asserted s_valid searching from pointer ptr upward, wrapping modulo NUM; combinational.
REQ-022 ptr resets to 0; after each transfer from channel g, ptr = (g+1) mod NUM (wrap NUM-1 -> 0).
REQ-023 No s_valid asserted: no grant, ptr unchanged, s_ready all 0.
REQ-024 grant never changes while ld=0; a channel's s_valid held high is never starved beyond NUM-1 other transfers.
REQ-025 s_data of a non-granted channel never reaches m_data.

Reset
REQ-026 While i_reset=1 at a clock edge: m_valid=0, m_data=0, m_id=0, m_last=0, ptr=0, lock state IDLE.
REQ-027 s_ready is 0 during the reset cycle; reset mid-operation discards the held beat and any open packet lock.

Configuration
REQ-028 Macro AXI_ARB_LAST_EN compiles in packet locking and the s_last port.
REQ-029 With AXI_ARB_LAST_EN: two states IDLE, LOCKED; IDLE -> LOCKED on a transfer with s_last=0, capturing owner g; LOCKED grants only owner; LOCKED -> IDLE on owner transfer with s_last=1; single-beat packets (s_last=1) stay IDLE.
REQ-030 In LOCKED, owner deasserting s_valid keeps the lock; no other channel granted; ptr updates only on the s_last=1 transfer.
REQ-031 Without AXI_ARB_LAST_EN: no lock state, re-arbitration every beat, m_last tied 1.

Structure
REQ-032 Shared package axi_ic_pkg holds the lock-state enum and the MODE constants shared with axi_skidbuffer.
REQ-033 One sub-module axi_rr_pick: combinational rotate-priority picker (s_valid, ptr -> one-hot grant, index).

Verification
REQ-034 All 4 valid, m_ready=1 from reset release: m_id sequence 0,1,2,3,0 one per cycle, first m_valid 1 cycle after first s_valid.
REQ-035 Only channel 2 valid, m_ready=0 for 3 cycles: m_valid=1, m_data held, s_ready=4'b0000 while stalled; one beat delivered when m_ready=1.
REQ-036 ptr=3, channels 0 and 3 valid: channel 3 granted first, then 0 (wrap).
REQ-037 AXI_ARB_LAST_EN, channel 1 sends 3 beats (last on 3rd) while channel 0 valid throughout: m_id=1,1,1 then 0; channel 1 gap mid-packet keeps s_ready[0]=0.
REQ-038 i_reset asserted with m_valid=1 and lock held: next cycle m_valid=0, m_id=0, ptr=0, channel 0 granted first afterward.
